// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states, IF/ID bundle and
// the bit positions of the fields the control unit decodes.
package cpu_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // Field positions, counted down from the instruction MSB.
  localparam int OP_MSB   = 0;
  localparam int INST_MSB = 2;
  localparam int IMM_BIT  = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, redirect flush and bubble insertion.
// Ports: load/flush/stall controls, instr/pc in, valid/instr/pc out.
module if_id_reg #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (valid_q && !stall_i) begin
      // consumed downstream with no refill: bubble
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, IF/ID.
// Ports: imem req/addr/rvalid/rdata, stall, redirect, IF/ID fields.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               id_valid_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [ADDR_W-1:0]  id_pc_o,
  output logic [1:0]         id_op_o,
  output logic [1:0]         id_inst_o,
  output logic               id_imm_o
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  hpc_q, hpc_d;
  logic [INSTR_W-1:0] hins_q, hins_d;
  logic               disc_q, disc_d;
  logic               ld, can_ld;
  logic [INSTR_W-1:0] ld_instr;
  logic [ADDR_W-1:0]  ld_pc;

  // a bubble is always overwritable
  assign can_ld    = !id_valid_o || !stall_i;
  assign imem_req  = (state_q == ISSUE) && !rst;
  assign imem_addr = imem_req ? pc_q : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    disc_d   = disc_q;
    hins_d   = hins_q;
    hpc_d    = hpc_q;
    ld       = 1'b0;
    ld_instr = imem_rdata;
    ld_pc    = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      unique case (state_q)
        ISSUE: begin
          disc_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            disc_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            disc_d  = 1'b1;
          end
        end
        HOLD:    state_d = ISSUE;
        default: state_d = ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            state_d = ISSUE;
            if (disc_q) begin
              disc_d = 1'b0;
            end else if (can_ld) begin
              ld   = 1'b1;
              pc_d = pc_q + INC;
            end else begin
              hins_d  = imem_rdata;
              hpc_d   = pc_q;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            ld       = 1'b1;
            ld_instr = hins_q;
            ld_pc    = hpc_q;
            pc_d     = pc_q + INC;
            state_d  = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      disc_q  <= 1'b0;
      hins_q  <= '0;
      hpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disc_q  <= disc_d;
      hins_q  <= hins_d;
      hpc_q   <= hpc_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld),
    .flush_i(redirect_i),
    .stall_i(stall_i),
    .instr_i(ld_instr),
    .pc_i   (ld_pc),
    .valid_o(id_valid_o),
    .instr_o(id_instr_o),
    .pc_o   (id_pc_o)
  );

  assign id_op_o   = id_instr_o[INSTR_W-1-OP_MSB -: 2];
  assign id_inst_o = id_instr_o[INSTR_W-1-INST_MSB -: 2];
  assign id_imm_o  = id_instr_o[INSTR_W-1-IMM_BIT];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences,
// randomized run against a transaction-level fetch model.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int AW = 32;
  localparam int IW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          redir = 1'b0;
  logic [AW-1:0] rpc = '0;
  logic          rvalid = 1'b0;
  logic [IW-1:0] rdata = '0;
  logic          req;
  logic [AW-1:0] addr;
  logic          idv;
  logic [IW-1:0] instr;
  logic [AW-1:0] ipc;
  logic [1:0]    op, inst;
  logic          imm;

  logic          rst_w = 1'b1;
  logic          rv_w = 1'b0;
  logic [IW-1:0] rd_w = '0;
  logic          req_w;
  logic [AW-1:0] addr_w;
  logic          idv_w;
  logic [IW-1:0] instr_w;
  logic [AW-1:0] ipc_w;
  logic [1:0]    op_w, inst_w;
  logic          imm_w;

  fetch_stage u_dut (
    .clk(clk), .rst(rst),
    .imem_req(req), .imem_addr(addr),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .stall_i(stall), .redirect_i(redir),
    .redirect_pc_i(rpc),
    .id_valid_o(idv), .id_instr_o(instr),
    .id_pc_o(ipc), .id_op_o(op),
    .id_inst_o(inst), .id_imm_o(imm)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w),
    .imem_req(req_w), .imem_addr(addr_w),
    .imem_rvalid(rv_w), .imem_rdata(rd_w),
    .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0),
    .id_valid_o(idv_w), .id_instr_o(instr_w),
    .id_pc_o(ipc_w), .id_op_o(op_w),
    .id_inst_o(inst_w), .id_imm_o(imm_w)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [IW-1:0] data;
  } pend_t;
  pend_t pq[$];
  int            lat = 1;
  logic [IW-1:0] mem_base = 32'hA000_0000;
  bit            rand_data = 0;
  bit            model_en = 0;
  bit            stray_ok = 0;

  logic [AW-1:0] m_pc;
  bit            m_inflight, m_stale, m_held_v;
  logic [IW-1:0] m_held_instr;
  logic [AW-1:0] m_held_pc;
  if_id_t        m_id;

  logic          s_req, s_idv;
  logic [AW-1:0] s_addr, s_ipc;
  logic [IW-1:0] s_instr;
  logic [1:0]    s_op, s_inst;
  logic          s_imm;

  logic          prev_req_w = 1'b0;
  logic [AW-1:0] wq[$];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit got, can, loaded;
    if (rst) begin
      m_pc = '0; m_inflight = 0; m_stale = 0;
      m_held_v = 0; m_held_instr = '0; m_held_pc = '0;
      m_id = '0;
      return;
    end
    got = m_inflight && rvalid;
    can = !m_id.valid || !stall;
    loaded = 0;
    if (redir) begin
      m_id.valid = 0;
      m_held_v = 0;
      if (got) begin
        m_inflight = 0; m_stale = 0;
      end else if (!m_held_v && s_req) begin
        m_inflight = 1; m_stale = 1;
      end else if (m_inflight) begin
        m_stale = 1;
      end
      m_pc = rpc;
    end else begin
      if (s_req) begin
        m_inflight = 1;
      end else if (got) begin
        m_inflight = 0;
        if (m_stale) m_stale = 0;
        else if (can) begin
          m_id = '{1'b1, rdata, m_pc};
          m_pc = m_pc + 4;
          loaded = 1;
        end else begin
          m_held_v = 1;
          m_held_instr = rdata;
          m_held_pc = m_pc;
        end
      end else if (m_held_v && !stall) begin
        m_id = '{1'b1, m_held_instr, m_held_pc};
        m_held_v = 0;
        m_pc = m_pc + 4;
        loaded = 1;
      end
      if (!loaded && m_id.valid && !stall) m_id.valid = 0;
    end
  endtask

  task automatic tick();
    bit e_req;
    rvalid = 0;
    rdata = '0;
    for (int i = 0; i < pq.size(); i++) begin
      if (pq[i].due == cyc) begin
        rvalid = 1;
        rdata = pq[i].data;
        pq.delete(i);
        break;
      end
    end
    rv_w = prev_req_w;
    rd_w = 32'h1234_5678;
    #1;
    s_req = req; s_addr = addr; s_idv = idv;
    s_ipc = ipc; s_instr = instr;
    s_op = op; s_inst = inst; s_imm = imm;
    if (req) begin
      pend_t p;
      p.due = cyc + lat;
      p.data = rand_data ? IW'($urandom) : mem_base + addr;
      pq.push_back(p);
    end
    prev_req_w = req_w;
    if (req_w) wq.push_back(addr_w);
    if (model_en) begin
      e_req = !rst && !m_inflight && !m_held_v;
      check("req", req, e_req);
      if (e_req) check("addr", addr, m_pc);
      check("id_valid", idv, m_id.valid);
      check("id_instr", instr, m_id.instr);
      check("id_pc", ipc, m_id.pc);
      check("id_op", op, m_id.instr[31:30]);
      check("id_inst", inst, m_id.instr[29:28]);
      check("id_imm", imm, m_id.instr[27]);
      if (rvalid && !rst && !stray_ok)
        check("rvalid_protocol", m_inflight, 1);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; redir = 0;
    pq.delete();
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    bit            rst, stall, req;
    logic [AW-1:0] addr;
    bit            v;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } vec_t;
  vec_t tv[12];

  initial begin
    bit found;
    tv[0]  = '{1, 0, 0, 0,  0, 0,  32'h0};
    tv[1]  = '{0, 0, 1, 0,  0, 0,  32'h0};
    tv[2]  = '{0, 0, 0, 0,  0, 0,  32'h0};
    tv[3]  = '{0, 0, 1, 4,  1, 0,  32'hA000_0000};
    tv[4]  = '{0, 0, 0, 0,  0, 0,  32'hA000_0000};
    tv[5]  = '{0, 1, 1, 8,  1, 4,  32'hA000_0004};
    tv[6]  = '{0, 1, 0, 0,  1, 4,  32'hA000_0004};
    tv[7]  = '{0, 1, 0, 0,  1, 4,  32'hA000_0004};
    tv[8]  = '{0, 0, 0, 0,  1, 4,  32'hA000_0004};
    tv[9]  = '{0, 0, 1, 12, 1, 8,  32'hA000_0008};
    tv[10] = '{0, 0, 0, 0,  0, 8,  32'hA000_0008};
    tv[11] = '{0, 0, 1, 16, 1, 12, 32'hA000_000C};

    #1;
    tick();
    model_en = 1;
    rst_w = 0;
    for (int i = 0; i < 12; i++) begin
      rst = tv[i].rst;
      stall = tv[i].stall;
      tick();
      check($sformatf("v%0d_req", i), s_req, tv[i].req);
      if (tv[i].req || tv[i].rst)
        check($sformatf("v%0d_addr", i), s_addr, tv[i].addr);
      check($sformatf("v%0d_valid", i), s_idv, tv[i].v);
      check($sformatf("v%0d_pc", i), s_ipc, tv[i].pc);
      check($sformatf("v%0d_instr", i), s_instr, tv[i].instr);
      if (i == 3) begin
        check("first_op", s_op, 2'b10);
        check("first_inst", s_inst, 2'b10);
        check("first_imm", s_imm, 1'b0);
      end
    end
    stall = 0;

    // redirect while waiting on a slow response
    lat = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = s_req && s_addr == 32'h10;
    end
    check("rw_find_req10", found, 1);
    redir = 1; rpc = 32'h100;
    tick();
    redir = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_req;
    end
    check("rw_next_req", found, 1);
    check("rw_next_addr", s_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_idv;
    end
    check("rw_valid_seen", found, 1);
    check("rw_first_pc", s_ipc, 32'h100);
    check("rw_first_instr", s_instr, 32'hA000_0100);

    // redirect in the same cycle as rvalid, under stall
    lat = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_req && s_addr == 32'h4;
    end
    check("rs_find_req4", found, 1);
    stall = 1;
    tick();
    tick();
    check("rs_req8", s_req && s_addr == 32'h8, 1);
    check("rs_valid_before", s_idv, 1);
    redir = 1; rpc = 32'h200;
    tick();
    redir = 0;
    tick();
    check("rs_valid_after", s_idv, 0);
    check("rs_req", s_req, 1);
    check("rs_addr", s_addr, 32'h200);
    stall = 0;
    tick();
    tick();

    // consume without refill
    lat = 3;
    do_reset();
    stall = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_idv;
    end
    check("cn_valid_seen", found, 1);
    stall = 0;
    tick();
    check("cn_wait_valid", s_idv, 1);
    check("cn_wait_noreq", s_req, 0);
    tick();
    check("cn_bubble", s_idv, 0);
    check("cn_keep_pc", s_ipc, 32'h0);
    check("cn_keep_instr", s_instr, 32'hA000_0000);

    // reset while waiting: late response must be ignored
    lat = 3;
    mem_base = 32'hA000_0000;
    do_reset();
    tick();
    check("rr_first_req", s_req, 1);
    mem_base = 32'hB000_0000;
    stray_ok = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    check("rr_restart_req", s_req, 1);
    check("rr_restart_addr", s_addr, 32'h0);
    stray_ok = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_idv;
    end
    check("rr_valid_seen", found, 1);
    check("rr_instr", s_instr, 32'hB000_0000);
    check("rr_pc", s_ipc, 32'h0);

    // randomized run against the model
    rand_data = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      stall = ($urandom_range(0, 99) < 30);
      redir = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF8;
      else rpc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    stall = 0; redir = 0;

    check("wrap_count", wq.size() >= 2, 1);
    if (wq.size() >= 2) begin
      check("wrap_addr0", wq[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wq[1], 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
